// File: rtl/iob_cache_be_arbiter_pkg.sv
// Shared types and helpers for the cache back-end arbiter and its
// round-robin selector.
package iob_cache_be_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      RDATA = 2'd2
   } arb_state_t;

   // Selector width; a single-bit index is kept even for one master.
   function automatic int sel_w(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/iob_cache_rr_arbiter.sv
// Combinational round-robin picker: first set request strictly after
// rr_ptr, wrapping around, returned both one-hot and encoded.
module iob_cache_rr_arbiter #(
   parameter int N_MASTERS = 2,
   parameter int SEL_W     = 1
) (
   input  logic [N_MASTERS-1:0] req,
   input  logic [SEL_W-1:0]     rr_ptr,
   output logic [N_MASTERS-1:0] grant,
   output logic [SEL_W-1:0]     grant_idx,
   output logic                 any_req
);

   always_comb begin
      int   idx;
      logic found;
      grant     = '0;
      grant_idx = '0;
      any_req   = |req;
      found     = 1'b0;
      idx       = 0;
      for (int i = 1; i <= N_MASTERS; i++) begin
         idx = (int'(rr_ptr) + i) % N_MASTERS;
         if (!found && req[idx]) begin
            found          = 1'b1;
            grant[idx]     = 1'b1;
            grant_idx      = SEL_W'(idx);
         end
      end
   end

endmodule

// File: rtl/iob_cache_be_arbiter.sv
// Merges several cache back-end IOb ports onto one downstream port,
// one outstanding transaction at a time, round-robin between masters.
module iob_cache_be_arbiter
   import iob_cache_be_arbiter_pkg::*;
#(
   parameter int N_MASTERS = 2,
   parameter int ADDR_W    = 24,
   parameter int DATA_W    = 32
) (
   input  logic                          clk_i,
   input  logic                          cke_i,
   input  logic                          arst_n_i,
   input  logic [N_MASTERS-1:0]          m_valid_i,
   input  logic [N_MASTERS*ADDR_W-1:0]   m_addr_i,
   input  logic [N_MASTERS*DATA_W-1:0]   m_wdata_i,
   input  logic [N_MASTERS*DATA_W/8-1:0] m_wstrb_i,
   output logic [N_MASTERS-1:0]          m_ready_o,
   output logic [N_MASTERS-1:0]          m_rvalid_o,
   output logic [DATA_W-1:0]             m_rdata_o,
   output logic                          be_valid_o,
   output logic [ADDR_W-1:0]             be_addr_o,
   output logic [DATA_W-1:0]             be_wdata_o,
   output logic [DATA_W/8-1:0]           be_wstrb_o,
   input  logic                          be_ready_i,
   input  logic                          be_rvalid_i,
   input  logic [DATA_W-1:0]             be_rdata_i
);

   localparam int NBYTES = DATA_W / 8;
   localparam int SEL_W  = sel_w(N_MASTERS);

   arb_state_t             state;
   logic [SEL_W-1:0]       grant;
   logic [SEL_W-1:0]       rr_ptr;

   logic [N_MASTERS-1:0]   win_onehot;
   logic [SEL_W-1:0]       win_idx;
   logic                   any_req;

   logic [ADDR_W-1:0]      sel_addr;
   logic [DATA_W-1:0]      sel_wdata;
   logic [NBYTES-1:0]      sel_wstrb;

   iob_cache_rr_arbiter #(
      .N_MASTERS(N_MASTERS),
      .SEL_W    (SEL_W)
   ) u_rr (
      .req      (m_valid_i),
      .rr_ptr   (rr_ptr),
      .grant    (win_onehot),
      .grant_idx(win_idx),
      .any_req  (any_req)
   );

   // AND-OR payload mux driven by the one-hot winner.
   always_comb begin
      sel_addr  = '0;
      sel_wdata = '0;
      sel_wstrb = '0;
      for (int k = 0; k < N_MASTERS; k++) begin
         if (win_onehot[k]) begin
            sel_addr  = sel_addr  | m_addr_i [k*ADDR_W +: ADDR_W];
            sel_wdata = sel_wdata | m_wdata_i[k*DATA_W +: DATA_W];
            sel_wstrb = sel_wstrb | m_wstrb_i[k*NBYTES +: NBYTES];
         end
      end
   end

   // Payload is captured at grant so upstream changes before accept are
   // invisible downstream; a write is recognised by its latched strobe.
   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         state      <= IDLE;
         grant      <= '0;
         rr_ptr     <= SEL_W'(N_MASTERS - 1);
         be_valid_o <= 1'b0;
         be_addr_o  <= '0;
         be_wdata_o <= '0;
         be_wstrb_o <= '0;
      end else if (cke_i) begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  be_valid_o <= 1'b1;
                  be_addr_o  <= sel_addr;
                  be_wdata_o <= sel_wdata;
                  be_wstrb_o <= sel_wstrb;
                  grant      <= win_idx;
                  rr_ptr     <= win_idx;
                  state      <= REQ;
               end
            end
            REQ: begin
               if (be_ready_i) begin
                  be_valid_o <= 1'b0;
                  be_wstrb_o <= '0;
                  state      <= (|be_wstrb_o) ? IDLE : RDATA;
               end
            end
            RDATA: begin
               if (be_rvalid_i) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      m_ready_o  = '0;
      m_rvalid_o = '0;
      if (state == REQ)   m_ready_o[grant]  = be_ready_i;
      if (state == RDATA) m_rvalid_o[grant] = be_rvalid_i;
   end

   assign m_rdata_o = be_rdata_i;

endmodule
